// File: rtl/boot_loader_if.sv
// Byte-stream receive handshake plus boot RAM write port.
// master is the loader side; slave is the byte source / RAM side.
interface boot_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [9:0]  address;
  logic [1:0]  byteena;
  logic [15:0] data;
  logic        wren;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output address,
    output byteena,
    output data,
    output wren
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  address,
    input  byteena,
    input  data,
    input  wren
  );
endinterface

// File: rtl/boot_loader.sv
// Serial boot loader: parses A5-framed records into 16-bit boot RAM
// byte-lane writes, checks an additive checksum and gates CPU reset.
module boot_loader #(
  parameter bit HOLD_CPU = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  boot_loader_if.master bus,
  output logic          cpu_reset,
  output logic          busy,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE, AHI, ALO, CNT, DHI, DLO, CSUM
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] data_q, data_d;
  logic        wren_q, wren_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [7:0]  sum_q, sum_d;
  logic        inc_q, inc_d;
  logic        cpu_q, cpu_d;
  logic        err_q, err_d;

  logic       take;
  logic [7:0] b;
  logic [7:0] sum_add;

  assign bus.rx_ready = ~reset;
  assign take         = bus.rx_valid & bus.rx_ready;
  assign b            = bus.rx_data;
  assign sum_add      = sum_q + b;

  assign bus.address = addr_q;
  assign bus.byteena = be_q;
  assign bus.data    = data_q;
  assign bus.wren    = wren_q;
  assign cpu_reset   = cpu_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      inc_q   <= 1'b0;
      cpu_q   <= HOLD_CPU;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      inc_q   <= inc_d;
      cpu_q   <= cpu_d;
      err_q   <= err_d;
    end
  end

  // Address steps one cycle after the low-lane write so the write
  // cycle itself still presents the word being filled.
  always_comb begin
    state_d = state_q;
    addr_d  = inc_q ? addr_q + 10'd1 : addr_q;
    be_d    = be_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    inc_d   = 1'b0;
    cpu_d   = cpu_q;
    err_d   = err_q;
    if (take) begin
      unique case (state_q)
        IDLE: begin
          if (b == 8'hA5) begin
            state_d = AHI;
            sum_d   = '0;
            cpu_d   = 1'b1;
            err_d   = 1'b0;
          end else if (b == 8'h5A) begin
            cpu_d = 1'b0;
          end
        end
        AHI: begin
          addr_d[9:8] = b[1:0];
          if (|b[7:2]) err_d = 1'b1;
          sum_d   = sum_add;
          state_d = ALO;
        end
        ALO: begin
          addr_d[7:0] = b;
          sum_d   = sum_add;
          state_d = CNT;
        end
        CNT: begin
          // zero count encodes a full 256-word block
          cnt_d   = {(b == 8'd0), b};
          sum_d   = sum_add;
          state_d = DHI;
        end
        DHI: begin
          wren_d  = 1'b1;
          be_d    = 2'b10;
          data_d  = {b, b};
          sum_d   = sum_add;
          state_d = DLO;
        end
        DLO: begin
          wren_d  = 1'b1;
          be_d    = 2'b01;
          data_d  = {b, b};
          sum_d   = sum_add;
          inc_d   = 1'b1;
          cnt_d   = cnt_q - 9'd1;
          state_d = (cnt_q == 9'd1) ? CSUM : DHI;
        end
        CSUM: begin
          sum_d   = sum_add;
          if (sum_add != 8'd0) err_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: frames, wrap, checksum error,
// CPU reset control, async reset mid-frame and spaced input.
module tb_boot_loader;
  logic clk;
  logic reset;
  logic cpu_reset;
  logic busy;
  logic err;

  boot_loader_if bus();

  boot_loader #(.HOLD_CPU(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  fr[$];
  logic [27:0] wq[$];

  logic [27:0] exp_a [4] = '{
    {10'h010, 2'b10, 16'h1212},
    {10'h010, 2'b01, 16'h3434},
    {10'h011, 2'b10, 16'h5656},
    {10'h011, 2'b01, 16'h7878}
  };

  logic [27:0] exp_b [4] = '{
    {10'h3FF, 2'b10, 16'hAAAA},
    {10'h3FF, 2'b01, 16'hBBBB},
    {10'h000, 2'b10, 16'hCCCC},
    {10'h000, 2'b01, 16'hDDDD}
  };

  always @(negedge clk)
    if (bus.wren === 1'b1)
      wq.push_back({bus.address, bus.byteena, bus.data});

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    foreach (fr[i]) begin
      bus.rx_data  = fr[i];
      bus.rx_valid = 1'b1;
      @(negedge clk);
      if (gap != 0) begin
        bus.rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.wren !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wren got %b want 0", bus.wren);
    end
    vectors++;
    if (bus.address !== 10'h000) begin
      miscompares++;
      $display("FAIL reset_addr got %h want 000", bus.address);
    end
    vectors++;
    if ({bus.byteena, bus.data} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_be_data got %h want 0", {bus.byteena, bus.data});
    end
    vectors++;
    if ({err, busy, cpu_reset} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 001", {err, busy, cpu_reset});
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rx_ready got %b want 1", bus.rx_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_cpu_hold();
    send_byte(8'h5A);
    vectors++;
    if ({cpu_reset, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL cpu_5a got %b want 00", {cpu_reset, busy});
    end
    send_byte(8'h33);
    vectors++;
    if ({cpu_reset, busy, err} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_33 got %b want 000", {cpu_reset, busy, err});
    end
  endtask

  task automatic test_frame_a();
    logic [27:0] got;
    wq.delete();
    send_byte(8'hA5);
    vectors++;
    if ({cpu_reset, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL sync_a5 got %b want 11", {cpu_reset, busy});
    end
    fr = '{8'h00, 8'h10, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDA};
    send_frame(0);
    @(negedge clk);
    vectors++;
    if (wq.size() !== 4) begin
      miscompares++;
      $display("FAIL frame_a_count got %0d want 4", wq.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < wq.size()) ? wq[i] : 'x;
      vectors++;
      if (got !== exp_a[i]) begin
        miscompares++;
        $display("FAIL frame_a_w%0d got %h want %h", i, got, exp_a[i]);
      end
    end
    vectors++;
    if ({err, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL frame_a_flags got %b want 00", {err, busy});
    end
    vectors++;
    if (bus.address !== 10'h012) begin
      miscompares++;
      $display("FAIL frame_a_addr got %h want 012", bus.address);
    end
  endtask

  task automatic test_wrap_badsum();
    logic [27:0] got;
    wq.delete();
    fr = '{8'hA5, 8'h03, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    send_frame(0);
    @(negedge clk);
    vectors++;
    if (wq.size() !== 4) begin
      miscompares++;
      $display("FAIL frame_b_count got %0d want 4", wq.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < wq.size()) ? wq[i] : 'x;
      vectors++;
      if (got !== exp_b[i]) begin
        miscompares++;
        $display("FAIL frame_b_w%0d got %h want %h", i, got, exp_b[i]);
      end
    end
    vectors++;
    if ({err, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL frame_b_err got %b want 10", {err, busy});
    end
  endtask

  task automatic test_spaced();
    logic [27:0] got;
    wq.delete();
    send_byte(8'hA5);
    vectors++;
    if ({err, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL err_clear got %b want 01", {err, busy});
    end
    fr = '{8'h00, 8'h10, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDA};
    send_frame(1);
    @(negedge clk);
    vectors++;
    if (wq.size() !== 4) begin
      miscompares++;
      $display("FAIL spaced_count got %0d want 4", wq.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < wq.size()) ? wq[i] : 'x;
      vectors++;
      if (got !== exp_a[i]) begin
        miscompares++;
        $display("FAIL spaced_w%0d got %h want %h", i, got, exp_a[i]);
      end
    end
    vectors++;
    if ({err, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL spaced_flags got %b want 00", {err, busy});
    end
  endtask

  task automatic test_count_zero();
    int bad;
    logic [27:0] want;
    logic [7:0]  v;
    wq.delete();
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 512; i++) begin
      v = i[7:0];
      fr.push_back(v);
    end
    fr.push_back(8'h00);
    send_frame(0);
    @(negedge clk);
    vectors++;
    if (wq.size() !== 512) begin
      miscompares++;
      $display("FAIL cnt0_pulses got %0d want 512", wq.size());
    end
    bad = 0;
    for (int j = 0; j < 512; j++) begin
      v = j[7:0];
      want = {10'(j >> 1), (j[0] ? 2'b01 : 2'b10), v, v};
      if (j >= wq.size() || wq[j] !== want) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL cnt0_entries got %0d bad want 0", bad);
    end
    vectors++;
    if ({err, busy, bus.address} !== {2'b00, 10'h100}) begin
      miscompares++;
      $display("FAIL cnt0_end got %b/%h want 00/100", {err, busy}, bus.address);
    end
  endtask

  task automatic test_async_reset();
    logic [27:0] got;
    fr = '{8'hA5, 8'h00, 8'h20, 8'h01, 8'h11};
    send_frame(0);
    vectors++;
    if ({bus.wren, bus.byteena} !== 3'b110) begin
      miscompares++;
      $display("FAIL mid_dhi got %b want 110", {bus.wren, bus.byteena});
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({bus.wren, busy, err} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_rst got %b want 000", {bus.wren, busy, err});
    end
    vectors++;
    if ({bus.address, bus.data, cpu_reset} !== {10'h0, 16'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL async_rst_regs got %h/%h/%b want 0/0/1",
               bus.address, bus.data, cpu_reset);
    end
    @(negedge clk);
    reset = 1'b0;
    wq.delete();
    fr = '{8'hA5, 8'h00, 8'h10, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDA};
    send_frame(0);
    @(negedge clk);
    vectors++;
    if (wq.size() !== 4) begin
      miscompares++;
      $display("FAIL post_rst_count got %0d want 4", wq.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < wq.size()) ? wq[i] : 'x;
      vectors++;
      if (got !== exp_a[i]) begin
        miscompares++;
        $display("FAIL post_rst_w%0d got %h want %h", i, got, exp_a[i]);
      end
    end
    vectors++;
    if ({err, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL post_rst_flags got %b want 00", {err, busy});
    end
  endtask

  initial begin
    test_reset();
    test_cpu_hold();
    test_frame_a();
    test_wrap_badsum();
    test_spaced();
    test_count_zero();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
